// File: rtl/dlx_pkg.sv
// Shared encodings for the DLX memory/write-back path.
//   load_type_e : load extraction modes driven by the decode stage
//   WB_*        : bit positions inside the 2-bit write-back control field
package dlx_pkg;

  localparam int LOAD_TYPE_W = 3;
  localparam int WB_CTRL_W   = 2;

  // Write-back control bit indices.
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEM2REG  = 1;

  // Load extraction modes; codes 101..111 are undefined and act as LW.
  typedef enum logic [LOAD_TYPE_W-1:0] {
    LW  = 3'b000,
    LB  = 3'b001,
    LBU = 3'b010,
    LH  = 3'b011,
    LHU = 3'b100
  } load_type_e;

  // True for the modes that sign-extend the extracted field.
  function automatic logic load_is_signed(input logic [LOAD_TYPE_W-1:0] lt);
    return (lt == LB) || (lt == LH);
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Load aligner: picks the addressed byte/halfword out of a big-endian
// memory word and extends it to the full datapath width.
// Ports:
//   raw_i       - word returned by data memory
//   offset_i    - byte offset within the word (ALU result [1:0])
//   load_type_i - extraction mode (dlx_pkg::load_type_e encodings)
//   data_o      - extracted and extended value
// Purely combinational.
module load_aligner
  import dlx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]      raw_i,
  input  logic [1:0]             offset_i,
  input  logic [LOAD_TYPE_W-1:0] load_type_i,
  output logic [DATA_W-1:0]      data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  // Big-endian: offset 0 addresses the most significant byte.
  always_comb begin
    byte_sel = raw_i[DATA_W-1 -: 8];
    case (offset_i)
      2'd0: byte_sel = raw_i[DATA_W-1  -: 8];
      2'd1: byte_sel = raw_i[DATA_W-9  -: 8];
      2'd2: byte_sel = raw_i[DATA_W-17 -: 8];
      2'd3: byte_sel = raw_i[DATA_W-25 -: 8];
      default: byte_sel = raw_i[DATA_W-1 -: 8];
    endcase
  end

  // Halfword loads ignore offset bit 0, so misaligned halves round down.
  always_comb begin
    half_sel = offset_i[1] ? raw_i[15:0] : raw_i[DATA_W-1 -: 16];
  end

  assign sign_ext = load_is_signed(load_type_i);

  always_comb begin
    data_o = raw_i;
    case (load_type_i)
      LB, LBU: data_o = {{(DATA_W-8){sign_ext & byte_sel[7]}}, byte_sel};
      LH, LHU: data_o = {{(DATA_W-16){sign_ext & half_sel[15]}}, half_sel};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage of the DLX pipeline.
// Latches the memory-stage results, aligns loaded data, and drives the
// register-bank write port and the forwarding unit. Counts retired
// instructions.
// Ports:
//   clock, reset       - rising-edge clock, async active-high reset
//   stall, flush       - hold contents / insert bubble (flush wins)
//   valid_in           - memory stage holds a real instruction
//   WB_control         - {mem_to_reg, reg_write}
//   load_type          - load extraction mode
//   data_from_mem      - data-memory read word
//   data_from_ALU      - ALU result (also the memory address)
//   reg_write          - destination register
//   wb_we/addr/data    - register-bank write port
//   valid_out          - stage holds a real instruction
//   retired_count      - retired-instruction counter (wraps silently)
module mem_wb_stage
  import dlx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [WB_CTRL_W-1:0]   WB_control,
  input  logic [LOAD_TYPE_W-1:0] load_type,
  input  logic [DATA_W-1:0]      data_from_mem,
  input  logic [DATA_W-1:0]      data_from_ALU,
  input  logic [REG_AW-1:0]      reg_write,
  output logic                   wb_we,
  output logic [REG_AW-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   valid_out,
  output logic [CNT_W-1:0]       retired_count
);

  logic                   valid_q, valid_d;
  logic [WB_CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [LOAD_TYPE_W-1:0] lt_q, lt_d;
  logic [DATA_W-1:0]      mem_q, mem_d;
  logic [DATA_W-1:0]      alu_q, alu_d;
  logic [REG_AW-1:0]      rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [DATA_W-1:0]      aligned;

  // Flush only needs to kill valid and control; the payload registers are
  // masked at the outputs whenever valid is low, so they simply hold.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    lt_d    = lt_q;
    mem_d   = mem_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall) begin
      valid_d = valid_in;
      ctrl_d  = WB_control;
      lt_d    = load_type;
      mem_d   = data_from_mem;
      alu_d   = data_from_ALU;
      rd_d    = reg_write;
      if (valid_in) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      lt_q    <= '0;
      mem_q   <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      lt_q    <= lt_d;
      mem_q   <= mem_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  load_aligner #(
    .DATA_W (DATA_W)
  ) u_load_aligner (
    .raw_i       (mem_q),
    .offset_i    (alu_q[1:0]),
    .load_type_i (lt_q),
    .data_o      (aligned)
  );

  // Outputs depend on the latch registers only.
  assign valid_out     = valid_q;
  assign wb_we         = valid_q & ctrl_q[WB_REGWRITE] & (rd_q != '0);
  assign wb_addr       = valid_q ? rd_q : '0;
  assign wb_data       = !valid_q              ? '0 :
                         ctrl_q[WB_MEM2REG]    ? aligned : alu_q;
  assign retired_count = cnt_q;

endmodule
